instr_fetch: RTL
================

Name: instr_fetch

Overview:
Instruction fetch stage directly upstream of the decode stage. It owns the PC and issues word-aligned requests to instruction memory over a req/gnt/rvalid interface. Returned words are buffered in a small FIFO and presented to decode as {instr, instr_pc} under a valid/ready handshake. A redirect input from the later stages (branch/jump) flushes the stream and restarts fetch at a new PC.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first fetch after reset
FIFO_DEPTH, 2, instruction buffer entries; power of two, >= 2

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch byte address, bits [1:0] always 0
imem_gnt  input  1  request accepted this cycle (meaningful only while imem_req=1)
imem_rvalid  input  1  response data valid; responses return in request order
imem_rdata  input  32  instruction word
redirect_valid  input  1  flush and restart fetch at redirect_pc
redirect_pc  input  32  new PC; bits [1:0] ignored (treated as 0)
instr_valid  output  1  instr/instr_pc valid toward decode
instr_ready  input  1  decode accepts the current instruction
instr  output  32  instruction word to decode
instr_pc  output  32  address of instr

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC; imem_req=0; imem_addr=RESET_PC; instr_valid=0; instr=0; instr_pc=0; FIFO empty; outstanding=0; drop_cnt=0; FSM=BOOT.
- FSM: BOOT -> RUN one cycle after reset deasserts, unconditionally. RUN has no exit except reset. No requests are issued in BOOT.
- Credit: imem_req = (state==RUN) && !redirect_valid && (fifo_count + outstanding < FIFO_DEPTH). A full FIFO can never overflow. An rvalid arriving while the FIFO is full is a design error (assertion).
- imem_addr = pc (combinational from the register). While imem_req=1 and gnt=0, pc holds stable.
- Accept (imem_req && imem_gnt): pc <= pc+4, wrapping modulo 2^32; outstanding++.
- Response (imem_rvalid): outstanding--. If drop_cnt>0, the data is discarded and drop_cnt--. Otherwise {imem_rdata, pc_of_response} is pushed. A PC shadow FIFO or response-PC counter tracks the address of each in-flight request.
- Latency: gnt in cycle N, rvalid earliest N+1, instr_valid earliest N+2. There is no bypass from rvalid to instr.
- Output: instr_valid = FIFO non-empty && !redirect_valid. Pop when instr_valid && instr_ready. instr/instr_pc show the FIFO head; they read 0 when the FIFO is empty.
- Redirect cycle (redirect_valid=1):
  - pc <= {redirect_pc[31:2],2'b00}.
  - FIFO cleared.
  - imem_req=0.
  - drop_cnt <= outstanding minus (1 if imem_rvalid this cycle).
  - Any pop is suppressed.
  - An rvalid in the same cycle is dropped.
  - Back-to-back redirects: the last one wins; drop_cnt accumulates correctly.
- Simultaneous push and pop with the FIFO full is impossible by credit. Push and pop in the same cycle on a non-empty FIFO leaves the count unchanged.
- Reset mid-transaction: all counters clear. Memory responses still in flight after reset are the memory's responsibility; the memory must be reset together with this block.

Decomposition:
- Shared package rv_pkg:
  - XLEN=32
  - ILEN=32
  - RESET_PC_DEFAULT
  - INSTR_NOP=32'h0000_0013
  - opcode constants (OP_IMM=7'b0010011, etc.), shared with decode
- Sub-module fetch_fifo: synchronous FIFO of {pc, instr} with DEPTH parameter, ports push/pop/flush/full/empty/count. Flush has priority over push.

Test Plan:
- Reset release, imem_gnt tied 1, rvalid one cycle after each gnt, instr_ready=1 -> requests at addresses 0x0,0x4,0x8,… on consecutive cycles; instr_pc follows the same sequence; first instr_valid 2 cycles after first gnt.
- instr_ready=0 for 10 cycles with memory always granting -> exactly FIFO_DEPTH requests issued, then imem_req=0. When ready returns, instructions drain in order with no loss or duplication.
- imem_gnt low for 3 cycles at addr 0x8 -> imem_req stays high and imem_addr stays 0x8 throughout; pc advances only on the gnt cycle.
- Two requests outstanding (0x10, 0x14), redirect to 0x203 -> both responses dropped; next request at 0x200; first delivered instr_pc=0x200; instr_valid low in the redirect cycle.
- Redirect coincident with rvalid and a pending pop -> rvalid data dropped, no pop counted; drop_cnt equals remaining outstanding; fetch resumes at the redirect PC.
- Assert rst_n low mid-stream with FIFO half full -> all outputs return to reset values immediately (asynchronously); first request after release goes to RESET_PC following one BOOT cycle.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32 front-end definitions: widths, reset PC, opcodes and fetch-stage types.
package rv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [ILEN-1:0] INSTR_NOP        = 32'h0000_0013;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic {
    ST_BOOT,
    ST_RUN
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory req/gnt/rvalid channel and the decode valid/ready channel.
interface instr_fetch_if;
  import rv_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [ILEN-1:0] imem_rdata;

  logic            instr_valid;
  logic            instr_ready;
  logic [ILEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous {pc, instr} buffer between memory responses and decode; flush beats push.
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           din,
  output fetch_entry_t           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  rd_ptr_q;
  logic [AW-1:0]  wr_ptr_q;
  logic [AW:0]    count_q;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, issues credit-limited memory requests and buffers responses for decode.
module instr_fetch
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_if.master      bus,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e     state_q, state_d;
  logic             fetch_en;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  rsp_pc_q;
  logic [CW-1:0]    outstanding_q;
  logic [CW-1:0]    drop_cnt_q;
  logic [CW-1:0]    fifo_count;
  logic [CW:0]      credit_used;
  logic             fifo_full, fifo_empty;
  logic             accept, push, pop, drop_rsp;
  fetch_entry_t     fifo_din, fifo_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    fetch_en = 1'b0;
    case (state_q)
      ST_BOOT: state_d  = ST_RUN;
      ST_RUN:  fetch_en = 1'b1;
    endcase
  end

  // Credit counts buffered entries plus every in-flight request, so a response always has a slot.
  assign credit_used   = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign bus.imem_req  = fetch_en && !redirect_valid && (credit_used < (CW+1)'(FIFO_DEPTH));
  assign bus.imem_addr = pc_q;
  assign accept        = bus.imem_req && bus.imem_gnt;

  assign drop_rsp = bus.imem_rvalid && (redirect_valid || (drop_cnt_q != '0));
  assign push     = bus.imem_rvalid && !drop_rsp;
  assign fifo_din = '{pc: rsp_pc_q, instr: bus.imem_rdata};

  assign bus.instr_valid = !fifo_empty && !redirect_valid;
  assign pop             = bus.instr_valid && bus.instr_ready;
  assign bus.instr       = fifo_dout.instr;
  assign bus.instr_pc    = fifo_dout.pc;

  // rsp_pc_q only advances on kept responses: after a redirect the surviving stream
  // starts at the redirect target, so dropped words never consume an address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      outstanding_q <= outstanding_q + CW'(accept) - CW'(bus.imem_rvalid);
      if (redirect_valid) begin
        pc_q       <= word_align(redirect_pc);
        rsp_pc_q   <= word_align(redirect_pc);
        drop_cnt_q <= outstanding_q - CW'(bus.imem_rvalid);
      end else begin
        if (accept) pc_q <= pc_q + 32'd4;
        if (bus.imem_rvalid) begin
          if (drop_cnt_q != '0) drop_cnt_q <= drop_cnt_q - 1'b1;
          else                  rsp_pc_q   <= rsp_pc_q + 32'd4;
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  a_no_rvalid_when_full : assert property (
    @(posedge clk) disable iff (!rst_n) !(bus.imem_rvalid && fifo_full)
  );

endmodule
